// File: rtl/mc6809_bus_responder_if.sv
// CPU memory bus and console drain port of the MC6809 bus responder.
// The slave modport is the responder side; the master modport is the CPU/console side.
interface mc6809_bus_responder_if;
    logic        cpu_we_i;
    logic        cpu_oe_i;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic [7:0]  cpu_data_o;
    logic [7:0]  console_data_o;
    logic        console_valid_o;
    logic        console_ready_i;

    modport slave (
        input  cpu_we_i, cpu_oe_i, cpu_addr_i, cpu_data_i, console_ready_i,
        output cpu_data_o, console_data_o, console_valid_o
    );

    modport master (
        output cpu_we_i, cpu_oe_i, cpu_addr_i, cpu_data_i, console_ready_i,
        input  cpu_data_o, console_data_o, console_valid_o
    );
endinterface

// File: rtl/mc6809_bus_responder.sv
// Slave end of the MC6809 memory bus: on-chip RAM, fixed vector table and a
// 4-register I/O window fronting a console transmit FIFO.
module mc6809_bus_responder #(
    parameter int          RAM_AW     = 11,
    parameter logic [15:0] IO_BASE    = 16'hE000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] RESET_VEC  = 16'h0100,
    parameter logic [15:0] IRQ_VEC    = 16'h0200
) (
    input  logic                    clk32_i,
    input  logic                    reset_i,
    mc6809_bus_responder_if.slave   bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    ram_q [2**RAM_AW];
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];

    logic [7:0]    cpu_data_q, cpu_data_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    scratch_q, scratch_d;

    logic          wr_cyc, rd_cyc;
    logic          io_hit, vec_hit, ram_hit;
    logic [1:0]    io_off;
    logic          fifo_empty, fifo_full;
    logic          pop, push_req, push_ok, ovf_clr;
    logic          ram_we;
    logic [15:0]   vec_word;
    logic [7:0]    vec_byte;
    logic [7:0]    rd_data;

    always_comb begin
        wr_cyc  = bus.cpu_we_i;
        rd_cyc  = !bus.cpu_we_i && bus.cpu_oe_i;
        io_hit  = (bus.cpu_addr_i[15:2] == IO_BASE[15:2]);
        vec_hit = !io_hit && (bus.cpu_addr_i[15:4] == 12'hFFF);
        ram_hit = !io_hit && !vec_hit && (bus.cpu_addr_i[15:RAM_AW] == '0);
        io_off  = bus.cpu_addr_i[1:0];

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        // Pop only a valid head, so a push into an empty FIFO never pops on the same edge.
        pop      = !fifo_empty && bus.console_ready_i;
        push_req = wr_cyc && io_hit && (io_off == 2'd0);
        push_ok  = push_req && (!fifo_full || pop);
        ovf_clr  = wr_cyc && io_hit && (io_off == 2'd1) && bus.cpu_data_i[2];
        ram_we   = wr_cyc && ram_hit;

        vec_word = (bus.cpu_addr_i[3:1] == 3'b111) ? RESET_VEC : IRQ_VEC;
        vec_byte = bus.cpu_addr_i[0] ? vec_word[7:0] : vec_word[15:8];

        rd_data = 8'hFF;
        if (io_hit) begin
            case (io_off)
                2'd0:    rd_data = 8'h00;
                2'd1:    rd_data = {5'b0, overflow_q, fifo_full, fifo_empty};
                2'd2:    rd_data = 8'(count_q);
                default: rd_data = scratch_q;
            endcase
        end else if (vec_hit) begin
            rd_data = vec_byte;
        end else if (ram_hit) begin
            rd_data = ram_q[bus.cpu_addr_i[RAM_AW-1:0]];
        end

        cpu_data_d = rd_cyc ? rd_data : cpu_data_q;
        scratch_d  = (wr_cyc && io_hit && io_off == 2'd3) ? bus.cpu_data_i : scratch_q;
        // A rejected push on the same edge as a clear leaves overflow set.
        overflow_d = (push_req && !push_ok) || (overflow_q && !ovf_clr);

        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push_ok)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk32_i or posedge reset_i) begin
        if (reset_i) begin
            cpu_data_q <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            scratch_q  <= 8'h00;
        end else begin
            cpu_data_q <= cpu_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            scratch_q  <= scratch_d;
        end
    end

    // Storage arrays are not reset; the FIFO head is masked while empty instead.
    always_ff @(posedge clk32_i) begin
        if (ram_we)
            ram_q[bus.cpu_addr_i[RAM_AW-1:0]] <= bus.cpu_data_i;
        if (push_ok && !reset_i)
            fifo_mem_q[wr_ptr_q] <= bus.cpu_data_i;
    end

    assign bus.cpu_data_o      = cpu_data_q;
    assign bus.console_valid_o = !fifo_empty;
    assign bus.console_data_o  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mc6809_bus_responder.sv
// Directed bench for mc6809_bus_responder: CPU read results and console bytes
// are queued as expectations when stimulus is driven and compared on output.
module tb_mc6809_bus_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] rd_q[$];
    logic [7:0] cons_q[$];

    mc6809_bus_responder_if bus_if ();

    mc6809_bus_responder dut (
        .clk32_i (clk),
        .reset_i (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.cpu_we_i   = 1'b1;
        bus_if.cpu_oe_i   = 1'b0;
        bus_if.cpu_addr_i = a;
        bus_if.cpu_data_i = d;
        @(posedge clk); #1;
        bus_if.cpu_we_i = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus_if.cpu_we_i   = 1'b0;
        bus_if.cpu_oe_i   = 1'b1;
        bus_if.cpu_addr_i = a;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        bus_if.cpu_oe_i = 1'b0;
        check(tag, bus_if.cpu_data_o, rd_q.pop_front());
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus_if.console_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40 && cons_q.size() != 0; cyc++) begin
            if (bus_if.console_valid_o)
                check(tag, bus_if.console_data_o, cons_q.pop_front());
            @(posedge clk); #1;
        end
        bus_if.console_ready_i = 1'b0;
        check({tag, "_complete"}, 8'(cons_q.size()), 8'd0);
        check({tag, "_valid_low"}, 8'(bus_if.console_valid_o), 8'd0);
    endtask

    initial begin
        bus_if.cpu_we_i        = 1'b0;
        bus_if.cpu_oe_i        = 1'b0;
        bus_if.cpu_addr_i      = 16'h0000;
        bus_if.cpu_data_i      = 8'h00;
        bus_if.console_ready_i = 1'b0;

        #12;
        check("rst_cpu_data", bus_if.cpu_data_o, 8'h00);
        check("rst_valid", 8'(bus_if.console_valid_o), 8'h00);
        check("rst_cons_data", bus_if.console_data_o, 8'h00);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cpu_read(16'hE001, 8'h01, "rst_status");
        cpu_read(16'hE003, 8'h00, "rst_scratch");
        cpu_read(16'hE002, 8'h00, "rst_count");

        // RAM and decode
        cpu_write(16'h0010, 8'h5A);
        cpu_read(16'h0010, 8'h5A, "ram_rd");
        @(posedge clk); #1;
        check("idle_hold", bus_if.cpu_data_o, 8'h5A);
        cpu_write(16'h07FF, 8'hC3);
        cpu_read(16'h07FF, 8'hC3, "ram_top");
        cpu_read(16'hFFFE, 8'h01, "vec_reset_hi");
        cpu_read(16'hFFFF, 8'h00, "vec_reset_lo");
        cpu_read(16'hFFF8, 8'h02, "vec_irq_hi");
        cpu_read(16'hFFF1, 8'h00, "vec_irq_lo");
        cpu_read(16'h8000, 8'hFF, "unmapped");
        cpu_read(16'h0800, 8'hFF, "ram_above");
        cpu_write(16'hFFFE, 8'h12);
        cpu_read(16'hFFFE, 8'h01, "vec_wr_ignored");
        cpu_read(16'hE000, 8'h00, "txdata_rd");

        // FIFO fill past full, then drain
        for (int i = 1; i <= 9; i++) begin
            cpu_write(16'hE000, 8'(i));
            if (i <= 8) cons_q.push_back(8'(i));
        end
        cpu_read(16'hE002, 8'h08, "fill_count");
        cpu_read(16'hE001, 8'h06, "fill_status");
        drain("drain1");
        cpu_read(16'hE001, 8'h05, "drained_status");
        cpu_write(16'hE001, 8'h04);
        cpu_read(16'hE001, 8'h01, "ovf_cleared");

        // Full FIFO: push with same-edge pop is accepted
        for (int i = 0; i < 8; i++) begin
            cpu_write(16'hE000, 8'(8'h11 + i));
            cons_q.push_back(8'(8'h11 + i));
        end
        @(negedge clk);
        bus_if.cpu_we_i        = 1'b1;
        bus_if.cpu_addr_i      = 16'hE000;
        bus_if.cpu_data_i      = 8'hAA;
        bus_if.console_ready_i = 1'b1;
        check("full_pop_head", bus_if.console_data_o, cons_q.pop_front());
        cons_q.push_back(8'hAA);
        @(posedge clk); #1;
        bus_if.cpu_we_i        = 1'b0;
        bus_if.console_ready_i = 1'b0;
        cpu_read(16'hE002, 8'h08, "full_pp_count");
        cpu_read(16'hE001, 8'h02, "full_pp_status");
        // Head must hold while not accepted
        @(posedge clk); #1;
        check("head_stall", bus_if.console_data_o, 8'h12);
        drain("drain2");

        // Scratch and write-wins
        cpu_write(16'hE003, 8'h3C);
        cpu_read(16'hE003, 8'h3C, "scratch");
        @(negedge clk);
        bus_if.cpu_we_i   = 1'b1;
        bus_if.cpu_oe_i   = 1'b1;
        bus_if.cpu_addr_i = 16'h0020;
        bus_if.cpu_data_i = 8'h77;
        rd_q.push_back(8'h3C);
        @(posedge clk); #1;
        bus_if.cpu_we_i = 1'b0;
        bus_if.cpu_oe_i = 1'b0;
        check("we_oe_hold", bus_if.cpu_data_o, rd_q.pop_front());
        cpu_read(16'h0020, 8'h77, "we_oe_ram");

        // Reset mid-drain
        for (int i = 0; i < 4; i++) cpu_write(16'hE000, 8'(8'h40 + i));
        @(negedge clk);
        bus_if.console_ready_i = 1'b1;
        check("pre_rst_head", bus_if.console_data_o, 8'h40);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", 8'(bus_if.console_valid_o), 8'h00);
        check("midrst_cpu_data", bus_if.cpu_data_o, 8'h00);
        check("midrst_cons_data", bus_if.console_data_o, 8'h00);
        cons_q.delete();
        @(negedge clk);
        bus_if.console_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cpu_read(16'hE002, 8'h00, "post_rst_count");
        cpu_read(16'hE003, 8'h00, "post_rst_scratch");
        cpu_read(16'h0020, 8'h77, "ram_survives_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
